// File: rtl/stage_two_pkg.sv
// -----------------------------------------------------------------------------
// stage_two_pkg
// Shared types and constants for the execute stage (stage_two) of the 16-bit
// pipelined CPU: operand width, MUL/DIV iteration count, memory-control and
// ALU operand structs, ALU control encoding and the MUL/DIV sequencer states.
// -----------------------------------------------------------------------------
package stage_two_pkg;

    localparam int DATA_W      = 16;
    localparam int MULDIV_ITER = DATA_W;
    localparam int INSTR_W     = 16;
    localparam int SHAMT_W     = $clog2(DATA_W);

    // Memory control carried alongside the instruction.
    typedef struct packed {
        logic mem2r;
        logic memwr;
    } memc_t;

    // ALU operand pair as delivered by fetch/decode.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_in_t;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        SLL = 4'd4,
        SRL = 4'd5,
        MUL = 4'd6,
        DIV = 4'd7
    } control_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/stage_two_if.sv
// -----------------------------------------------------------------------------
// stage_two_if
// Bundle between fetch/decode (master) and the execute stage (slave).
//   in_*      : flopped stage-one outputs consumed by execute
//   s3_data   : stage-three writeback data (R1 forwarding source)
//   busy      : stall request back to stage one
//   out_*     : flopped execute results for stage three
//   div0      : divide-by-zero flag, overflow : signed ADD/SUB overflow
// -----------------------------------------------------------------------------
interface stage_two_if;
    import stage_two_pkg::*;

    memc_t                 in_memc;
    logic                  in_reg_wr;
    alu_in_t               in_alu;
    control_e              in_alu_ctrl;
    logic                  in_haz1;
    logic                  in_haz2;
    logic                  in_haz8;
    logic                  in_R0_en;
    logic [INSTR_W-1:0]    in_instr;
    logic [DATA_W-1:0]     in_R1_data;
    logic [2*DATA_W-1:0]   s3_data;

    logic                  busy;
    logic [2*DATA_W-1:0]   out_alu;
    memc_t                 out_memc;
    logic                  out_reg_wr;
    logic                  out_R0_en;
    logic [INSTR_W-1:0]    out_instr;
    logic [DATA_W-1:0]     out_R1_data;
    logic                  div0;
    logic                  overflow;

    modport master (
        output in_memc, in_reg_wr, in_alu, in_alu_ctrl, in_haz1, in_haz2,
               in_haz8, in_R0_en, in_instr, in_R1_data, s3_data,
        input  busy, out_alu, out_memc, out_reg_wr, out_R0_en, out_instr,
               out_R1_data, div0, overflow
    );

    modport slave (
        input  in_memc, in_reg_wr, in_alu, in_alu_ctrl, in_haz1, in_haz2,
               in_haz8, in_R0_en, in_instr, in_R1_data, s3_data,
        output busy, out_alu, out_memc, out_reg_wr, out_R0_en, out_instr,
               out_R1_data, div0, overflow
    );

endinterface

// File: rtl/stage_two_muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Iterative unsigned multiply (shift-add) and restoring divide sequencer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   hold      : freeze all state (halt_sys)
//   start     : MUL/DIV requested by the instruction currently presented
//   op        : 1 = DIV, 0 = MUL
//   a, b      : forwarded operands
//   busy      : RUN, or IDLE with a pending start
//   accept    : start is taken this cycle (if not held)
//   done      : in DONE; result/div0 valid
//   result    : MUL product, or DIV {remainder, quotient}
//   div0      : DIV with b == 0
// -----------------------------------------------------------------------------
module muldiv_seq
    import stage_two_pkg::*;
#(
    parameter int DATA_W      = stage_two_pkg::DATA_W,
    parameter int MULDIV_ITER = stage_two_pkg::MULDIV_ITER
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic                start,
    input  logic                op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                busy,
    output logic                accept,
    output logic                done,
    output logic [2*DATA_W-1:0] result,
    output logic                div0
);

    localparam int CNT_W = $clog2(MULDIV_ITER);

    muldiv_state_e       state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // MUL: {partial product, remaining multiplier}; DIV: {remainder, quotient}.
    logic [2*DATA_W-1:0] work_q, work_d;
    // Multiplicand (MUL) or divisor (DIV).
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic                is_div_q, is_div_d;
    logic                div0_q, div0_d;

    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] div_next;

    // One shift-add step: add multiplicand when the low multiplier bit is set,
    // then shift the carry/product/multiplier chain right by one.
    assign mul_sum  = {1'b0, work_q[2*DATA_W-1:DATA_W]}
                    + (work_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, work_q[DATA_W-1:1]};

    // One restoring step: shift next dividend bit into the remainder, keep the
    // difference only when it did not go negative.
    assign div_shift = {work_q[2*DATA_W-1:DATA_W], work_q[DATA_W-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_next  = div_diff[DATA_W]
                     ? {div_shift[DATA_W-1:0], work_q[DATA_W-2:0], 1'b0}
                     : {div_diff[DATA_W-1:0],  work_q[DATA_W-2:0], 1'b1};

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves
        // it unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        accept   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    cnt_d    = '0;
                    is_div_d = op;
                    div0_d   = 1'b0;
                    if (op && (b == '0)) begin
                        // Divide by zero: no iterations, fixed result.
                        work_d  = {a, {DATA_W{1'b1}}};
                        opnd_d  = b;
                        div0_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        work_d  = op ? {{DATA_W{1'b0}}, a} : {{DATA_W{1'b0}}, b};
                        opnd_d  = op ? b : a;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                work_d = is_div_q ? div_next : mul_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MULDIV_ITER - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The same instruction is still presented here; never restart.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignment so every register samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
        end else if (!hold) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
        end
    end

    assign busy   = (state_q == RUN) || ((state_q == IDLE) && start);
    assign done   = (state_q == DONE);
    assign result = work_q;
    assign div0   = div0_q;

endmodule

// File: rtl/stage_two.sv
// -----------------------------------------------------------------------------
// stage_two
// Execute stage of the 16-bit pipelined CPU. Resolves execute forwarding
// (haz1/haz2 from the previous result, haz8 from stage-three data), runs the
// single-cycle ALU, and hands MUL/DIV to the iterative muldiv_seq while holding
// stage one through busy. All results are flopped for stage three.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset (wins over halt_sys)
//   halt_sys  : freeze all state and outputs
//   bus       : stage_two_if.slave (in_* from stage one, out_*/busy/flags out)
// Build option:
//   FAST_MUL_EN : when defined, MUL is a single-cycle combinational multiply;
//                 DIV stays iterative.
// -----------------------------------------------------------------------------
module stage_two
    import stage_two_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       halt_sys,
    stage_two_if.slave bus
);

    localparam int MSB = DATA_W - 1;

    // Output registers.
    logic [2*DATA_W-1:0] out_alu_q, out_alu_d;
    memc_t               out_memc_q, out_memc_d;
    logic                out_reg_wr_q, out_reg_wr_d;
    logic                out_r0_en_q, out_r0_en_d;
    logic [INSTR_W-1:0]  out_instr_q, out_instr_d;
    logic [DATA_W-1:0]   out_r1_q, out_r1_d;
    logic                div0_q, div0_d;
    logic                overflow_q, overflow_d;

    // Fields captured when a MUL/DIV is accepted, replayed in DONE.
    memc_t               lat_memc_q, lat_memc_d;
    logic                lat_reg_wr_q, lat_reg_wr_d;
    logic                lat_r0_en_q, lat_r0_en_d;
    logic [INSTR_W-1:0]  lat_instr_q, lat_instr_d;
    logic [DATA_W-1:0]   lat_r1_q, lat_r1_d;

    logic [DATA_W-1:0]   op_a, op_b, r1_fwd;
    logic [DATA_W-1:0]   add_r, sub_r;
    logic [2*DATA_W-1:0] alu_res;
    logic                alu_ovf;

    logic                seq_req, seq_op, seq_busy, seq_accept, seq_done, seq_div0;
    logic [2*DATA_W-1:0] seq_result;

    // Forwarding is resolved before any operand use.
    assign op_a   = bus.in_haz1 ? out_alu_q[DATA_W-1:0]   : bus.in_alu.a;
    assign op_b   = bus.in_haz2 ? out_alu_q[DATA_W-1:0]   : bus.in_alu.b;
    assign r1_fwd = bus.in_haz8 ? bus.s3_data[DATA_W-1:0] : bus.in_R1_data;

`ifdef FAST_MUL_EN
    assign seq_req = (bus.in_alu_ctrl == DIV);
`else
    assign seq_req = (bus.in_alu_ctrl == MUL) || (bus.in_alu_ctrl == DIV);
`endif
    assign seq_op  = (bus.in_alu_ctrl == DIV);

    muldiv_seq #(
        .DATA_W      (DATA_W),
        .MULDIV_ITER (MULDIV_ITER)
    ) u_muldiv_seq (
        .clk    (clk),
        .rst    (rst),
        .hold   (halt_sys),
        .start  (seq_req),
        .op     (seq_op),
        .a      (op_a),
        .b      (op_b),
        .busy   (seq_busy),
        .accept (seq_accept),
        .done   (seq_done),
        .result (seq_result),
        .div0   (seq_div0)
    );

    assign add_r = op_a + op_b;
    assign sub_r = op_a - op_b;

    // Single-cycle ALU; results are zero-extended to the full result bus.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.in_alu_ctrl)
            ADD: begin
                alu_res = {{DATA_W{1'b0}}, add_r};
                alu_ovf = (op_a[MSB] == op_b[MSB]) && (add_r[MSB] != op_a[MSB]);
            end
            SUB: begin
                alu_res = {{DATA_W{1'b0}}, sub_r};
                alu_ovf = (op_a[MSB] != op_b[MSB]) && (sub_r[MSB] != op_a[MSB]);
            end
            AND: alu_res = {{DATA_W{1'b0}}, op_a & op_b};
            OR:  alu_res = {{DATA_W{1'b0}}, op_a | op_b};
            SLL: alu_res = {{DATA_W{1'b0}}, op_a << op_b[SHAMT_W-1:0]};
            SRL: alu_res = {{DATA_W{1'b0}}, op_a >> op_b[SHAMT_W-1:0]};
`ifdef FAST_MUL_EN
            MUL: alu_res = (2*DATA_W)'(op_a) * (2*DATA_W)'(op_b);
`endif
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        lat_memc_d   = lat_memc_q;
        lat_reg_wr_d = lat_reg_wr_q;
        lat_r0_en_d  = lat_r0_en_q;
        lat_instr_d  = lat_instr_q;
        lat_r1_d     = lat_r1_q;
        if (seq_accept) begin
            lat_memc_d   = bus.in_memc;
            lat_reg_wr_d = bus.in_reg_wr;
            lat_r0_en_d  = bus.in_R0_en;
            lat_instr_d  = bus.in_instr;
            lat_r1_d     = r1_fwd;
        end
    end

    // Output selection: finished MUL/DIV, bubble while busy, else ALU result.
    always_comb begin
        out_alu_d    = '0;
        out_memc_d   = '0;
        out_reg_wr_d = 1'b0;
        out_r0_en_d  = 1'b0;
        out_instr_d  = '0;
        out_r1_d     = '0;
        div0_d       = 1'b0;
        overflow_d   = 1'b0;
        if (seq_done) begin
            out_alu_d    = seq_result;
            out_memc_d   = lat_memc_q;
            out_reg_wr_d = lat_reg_wr_q;
            out_r0_en_d  = lat_r0_en_q;
            out_instr_d  = lat_instr_q;
            out_r1_d     = lat_r1_q;
            div0_d       = seq_div0;
        end else if (!seq_busy) begin
            out_alu_d    = alu_res;
            out_memc_d   = bus.in_memc;
            out_reg_wr_d = bus.in_reg_wr;
            out_r0_en_d  = bus.in_R0_en;
            out_instr_d  = bus.in_instr;
            out_r1_d     = r1_fwd;
            overflow_d   = alu_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_alu_q    <= '0;
            out_memc_q   <= '0;
            out_reg_wr_q <= 1'b0;
            out_r0_en_q  <= 1'b0;
            out_instr_q  <= '0;
            out_r1_q     <= '0;
            div0_q       <= 1'b0;
            overflow_q   <= 1'b0;
            lat_memc_q   <= '0;
            lat_reg_wr_q <= 1'b0;
            lat_r0_en_q  <= 1'b0;
            lat_instr_q  <= '0;
            lat_r1_q     <= '0;
        end else if (!halt_sys) begin
            out_alu_q    <= out_alu_d;
            out_memc_q   <= out_memc_d;
            out_reg_wr_q <= out_reg_wr_d;
            out_r0_en_q  <= out_r0_en_d;
            out_instr_q  <= out_instr_d;
            out_r1_q     <= out_r1_d;
            div0_q       <= div0_d;
            overflow_q   <= overflow_d;
            lat_memc_q   <= lat_memc_d;
            lat_reg_wr_q <= lat_reg_wr_d;
            lat_r0_en_q  <= lat_r0_en_d;
            lat_instr_q  <= lat_instr_d;
            lat_r1_q     <= lat_r1_d;
        end
    end

    assign bus.busy        = seq_busy;
    assign bus.out_alu     = out_alu_q;
    assign bus.out_memc    = out_memc_q;
    assign bus.out_reg_wr  = out_reg_wr_q;
    assign bus.out_R0_en   = out_r0_en_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.out_R1_data = out_r1_q;
    assign bus.div0        = div0_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_stage_two.sv
// -----------------------------------------------------------------------------
// tb_stage_two
// Scoreboard bench for stage_two. Every real instruction is issued with
// in_reg_wr = 1 and a unique instruction word; its expected outputs and the
// cycle they must appear in are queued at issue time. A monitor pops and
// compares whenever out_reg_wr is high, so any bubble that leaks, any early or
// late result, or any wrong field is reported.
// -----------------------------------------------------------------------------
module tb_stage_two;
    import stage_two_pkg::*;

`ifdef FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_LAT  = 18;
    localparam int MUL_BUSY = 17;
`endif

    typedef struct {
        logic [31:0] alu;
        logic        ovf;
        logic        div0;
        logic [15:0] instr;
        logic [15:0] r1;
        logic [1:0]  memc;
        logic        r0;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halt_sys = 1'b0;

    stage_two_if bus ();

    stage_two dut (
        .clk      (clk),
        .rst      (rst),
        .halt_sys (halt_sys),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic nop_inputs();
        bus.in_alu_ctrl = ADD;
        bus.in_alu.a    = '0;
        bus.in_alu.b    = '0;
        bus.in_haz1     = 1'b0;
        bus.in_haz2     = 1'b0;
        bus.in_haz8     = 1'b0;
        bus.in_reg_wr   = 1'b0;
        bus.in_memc     = '0;
        bus.in_R0_en    = 1'b0;
        bus.in_instr    = '0;
        bus.in_R1_data  = '0;
    endtask

    // Monitor: a result is presented whenever out_reg_wr is high.
    always @(negedge clk) begin
        if (!rst && bus.out_reg_wr === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_result: got instr %h at cycle %0d, expected no output",
                         bus.out_instr, cyc);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("i%h.instr", mon_e.instr), bus.out_instr, mon_e.instr);
                check($sformatf("i%h.cycle", mon_e.instr), cyc, mon_e.cyc);
                check($sformatf("i%h.alu", mon_e.instr), bus.out_alu, mon_e.alu);
                check($sformatf("i%h.overflow", mon_e.instr), bus.overflow, mon_e.ovf);
                check($sformatf("i%h.div0", mon_e.instr), bus.div0, mon_e.div0);
                check($sformatf("i%h.r1", mon_e.instr), bus.out_R1_data, mon_e.r1);
                check($sformatf("i%h.memc", mon_e.instr), 32'(bus.out_memc), mon_e.memc);
                check($sformatf("i%h.r0_en", mon_e.instr), bus.out_R0_en, mon_e.r0);
            end
        end
    end

    // Present one instruction, hold it while busy (as stage one would), and
    // queue the expected result `lat` cycles after first presentation.
    // halt_at >= 0 raises halt_sys for 3 cycles starting at that cycle offset.
    task automatic issue(input control_e ctrl, input logic [15:0] a, input logic [15:0] b,
                         input logic h1, input logic h2, input logic h8,
                         input logic [15:0] instr, input logic [1:0] memc, input logic r0,
                         input logic [31:0] exp_alu, input logic exp_ovf, input logic exp_div0,
                         input int lat, input int exp_busy, input int halt_at);
        exp_t        e;
        logic [15:0] r1v;
        int          busy_cnt;
        int          k;
        logic        b_s;
        bit          fin;
        r1v     = instr ^ 16'h5555;
        e.alu   = exp_alu;
        e.ovf   = exp_ovf;
        e.div0  = exp_div0;
        e.instr = instr;
        e.r1    = h8 ? 16'hBEEF : r1v;
        e.memc  = memc;
        e.r0    = r0;
        e.cyc   = cyc + lat;
        sb.push_back(e);

        bus.in_alu_ctrl = ctrl;
        bus.in_alu.a    = a;
        bus.in_alu.b    = b;
        bus.in_haz1     = h1;
        bus.in_haz2     = h2;
        bus.in_haz8     = h8;
        bus.in_reg_wr   = 1'b1;
        bus.in_memc     = memc_t'(memc);
        bus.in_R0_en    = r0;
        bus.in_instr    = instr;
        bus.in_R1_data  = r1v;

        busy_cnt = 0;
        k        = 0;
        fin      = 1'b0;
        while (!fin) begin
            halt_sys = (halt_at >= 0) && (k >= halt_at) && (k < halt_at + 3);
            @(negedge clk);
            b_s = bus.busy;
            if (b_s === 1'b1) busy_cnt++;
            @(posedge clk);
            #1;
            k++;
            if (b_s !== 1'b1) begin
                fin = 1'b1;
            end else if (k > 100) begin
                n_checks++;
                n_err++;
                $display("FAIL i%h.busy_timeout: got busy still high after %0d cycles, expected release", instr, k);
                fin = 1'b1;
            end
        end
        halt_sys = 1'b0;
        nop_inputs();
        check($sformatf("i%h.busy_cycles", instr), busy_cnt, exp_busy);
    endtask

    initial begin
        nop_inputs();
        bus.s3_data = 32'hDEAD_BEEF;
        // Reset together with halt_sys: reset must win.
        rst      = 1'b1;
        halt_sys = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.out_alu",  bus.out_alu, 32'h0);
        check("reset.busy",     bus.busy, 1'b0);
        check("reset.reg_wr",   bus.out_reg_wr, 1'b0);
        check("reset.instr",    bus.out_instr, 16'h0);
        check("reset.div0",     bus.div0, 1'b0);
        check("reset.overflow", bus.overflow, 1'b0);
        check("reset.r1",       bus.out_R1_data, 16'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        halt_sys = 1'b0;

        //     ctrl a        b        h1 h2 h8 instr     memc  r0  exp_alu        ovf div0 lat      busy      halt
        issue(ADD, 16'h7FFF, 16'h0001, 0, 0, 0, 16'h1001, 2'b00, 0, 32'h0000_8000, 1, 0, 1,       0,        -1);
        issue(ADD, 16'h0002, 16'h0003, 0, 0, 0, 16'h1002, 2'b01, 1, 32'h0000_0005, 0, 0, 1,       0,        -1);
        issue(ADD, 16'h0000, 16'h0003, 1, 0, 0, 16'h1003, 2'b00, 0, 32'h0000_0008, 0, 0, 1,       0,        -1);
        issue(SUB, 16'h0010, 16'hAAAA, 0, 1, 0, 16'h1004, 2'b00, 0, 32'h0000_0008, 0, 0, 1,       0,        -1);
        issue(SUB, 16'h8000, 16'h0001, 0, 0, 0, 16'h1005, 2'b00, 0, 32'h0000_7FFF, 1, 0, 1,       0,        -1);
        issue(AND, 16'hF0F0, 16'h3C3C, 0, 0, 0, 16'h1006, 2'b00, 0, 32'h0000_3030, 0, 0, 1,       0,        -1);
        issue(OR,  16'hF0F0, 16'h0F00, 0, 0, 0, 16'h1007, 2'b10, 0, 32'h0000_FFF0, 0, 0, 1,       0,        -1);
        issue(SLL, 16'h0001, 16'h0004, 0, 0, 0, 16'h1008, 2'b00, 0, 32'h0000_0010, 0, 0, 1,       0,        -1);
        issue(SRL, 16'h8000, 16'h000F, 0, 0, 0, 16'h1009, 2'b00, 0, 32'h0000_0001, 0, 0, 1,       0,        -1);
        issue(ADD, 16'h0001, 16'h0001, 0, 0, 1, 16'h100A, 2'b11, 0, 32'h0000_0002, 0, 0, 1,       0,        -1);
        issue(MUL, 16'h00FF, 16'h0101, 0, 0, 0, 16'h100B, 2'b10, 1, 32'h0000_FFFF, 0, 0, MUL_LAT, MUL_BUSY, -1);
        issue(MUL, 16'hFFFF, 16'hFFFF, 0, 0, 1, 16'h100C, 2'b00, 1, 32'hFFFE_0001, 0, 0, MUL_LAT, MUL_BUSY, -1);
        issue(DIV, 16'd100,  16'd7,    0, 0, 0, 16'h100D, 2'b01, 0, 32'h0002_000E, 0, 0, 18,      17,       -1);
        issue(DIV, 16'h1234, 16'h0000, 0, 0, 0, 16'h100E, 2'b00, 1, 32'h1234_FFFF, 0, 1, 2,       1,        -1);
        issue(DIV, 16'hFFFF, 16'h0010, 0, 0, 1, 16'h100F, 2'b00, 0, 32'h000F_0FFF, 0, 0, 21,      20,       5);
        issue(ADD, 16'h0000, 16'h0001, 1, 0, 0, 16'h1010, 2'b00, 0, 32'h0000_1000, 0, 0, 1,       0,        -1);

        // Reset five cycles into a DIV: the operation is abandoned.
        bus.in_alu_ctrl = DIV;
        bus.in_alu.a    = 16'd100;
        bus.in_alu.b    = 16'd7;
        bus.in_reg_wr   = 1'b1;
        bus.in_instr    = 16'h2000;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        nop_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort.out_alu", bus.out_alu, 32'h0);
        check("abort.busy",    bus.busy, 1'b0);
        check("abort.reg_wr",  bus.out_reg_wr, 1'b0);
        check("abort.instr",   bus.out_instr, 16'h0);
        check("abort.div0",    bus.div0, 1'b0);
        @(posedge clk);
        #1;
        issue(DIV, 16'h1234, 16'h0000, 0, 0, 0, 16'h1011, 2'b00, 0, 32'h1234_FFFF, 0, 1, 2, 1, -1);

        repeat (25) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/stage_two.md
Name: stage_two

Overview:
Execute stage of the 16-bit pipelined CPU. It sits directly downstream of the fetch/decode stage and consumes its flopped outputs: ALU operands, ALU control, memory control, write enables, instruction and R1 data. It resolves execute-stage forwarding (haz1/haz2/haz8) and runs the ALU. MUL/DIV go through an iterative multi-cycle sequencer that holds the front end via busy. Results are flopped for stage three (s2_alu, s2_instruction, s2_R0_en).

Parameters:
DATA_W, 16, operand width; result bus is 2*DATA_W.
MULDIV_ITER, 16, iterations per MUL/DIV; equals DATA_W.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
halt_sys  in  1  freeze all state and outputs
in_memc  in  2  types_pkg::memc_t {mem2r, memwr}
in_reg_wr  in  1  register-write enable
in_alu  in  32  alu_pkg::in_t {a, b}
in_alu_ctrl  in  4  alu_pkg::control_e
in_haz1  in  1  forward previous out_alu[15:0] to operand a
in_haz2  in  1  forward previous out_alu[15:0] to operand b
in_haz8  in  1  forward s3_data[15:0] to R1 (store) data
in_R0_en  in  1  upper result half written to R0
in_instr  in  16  instruction
in_R1_data  in  16  R1 / store data
s3_data  in  32  stage-three writeback data
busy  out  1  combinational stall request to stage one
out_alu  out  32  result; upper half is R0 data
out_memc  out  2  flopped memc
out_reg_wr  out  1  flopped reg_wr
out_R0_en  out  1  flopped R0_en
out_instr  out  16  flopped instruction
out_R1_data  out  16  flopped, forwarded R1 data
div0  out  1  flopped divide-by-zero flag
overflow  out  1  flopped signed ADD/SUB overflow

Behaviour:
- Reset:
  - Synchronous; all outputs 0, out_alu_ctrl-derived state IDLE, iteration counter 0.
  - Reset during RUN aborts the operation; no result is produced.
- Forwarding is resolved before operand use:
  - a = haz1 ? out_alu[15:0] : in_alu.a
  - b = haz2 ? out_alu[15:0] : in_alu.b
  - R1 = haz8 ? s3_data[15:0] : in_R1_data
- Single-cycle ops (ADD, SUB, AND, OR, SLL, SRL):
  - Result is zero-extended to 32 bits and captured at the next edge.
  - Latency is 1; busy = 0.
- overflow is set only for ADD/SUB, when the sign of a and b agree (ADD) or differ (SUB) and the result sign differs from a. Otherwise 0.
- MUL/DIV FSM:
  - States: IDLE, RUN, DONE.
  - IDLE & start (ctrl ∈ {MUL, DIV}, !halt_sys): latch a, b and all in_* fields; counter = 0; go to RUN.
  - RUN: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle. At counter == MULDIV_ITER-1, go to DONE.
  - DONE: output registers capture the result with the latched fields; go to IDLE.
  - busy = (state == RUN) | (state == IDLE & start). busy = 0 in DONE, so stage one advances on that same edge. DONE never re-starts.
- While busy, output registers load a bubble: out_reg_wr = 0, out_memc = 0, out_R0_en = 0, out_instr = 0.
- Latency: instruction first presented in cycle 0 → result visible in cycle 18 (1 latch + 16 RUN + 1 DONE).
- MUL: unsigned; out_alu = full 32-bit product.
- DIV: unsigned; out_alu = {remainder, quotient}.
- DIV with b == 0:
  - IDLE → DONE directly, skipping RUN (visible cycle 2).
  - quotient = 16'hFFFF, remainder = a, div0 = 1.
  - div0 = 0 for all other operations.
- halt_sys: FSM, counter, working registers and outputs all hold. busy retains its value.
- halt_sys & rst together: rst wins.

Optional Feature:
FAST_MUL_EN:
- Defined: MUL is single-cycle (DATA_W×DATA_W combinational multiply), busy = 0, latency 1. DIV is unchanged.
- Undefined: MUL is iterative as above.

Decomposition:
- alu_pkg gains:
  - MULDIV_ITER constant
  - muldiv_state_e {IDLE, RUN, DONE}
  - control_e members MUL, DIV (if not already present)
- types_pkg: memc_t reused unchanged.
- One sub-module, muldiv_seq:
  - Contains the FSM, counter, and product/remainder shift registers.
  - Interface: start, op, a, b → busy, done, result[31:0], div0.

Test Plan:
- ADD a = 16'h7FFF, b = 16'h0001 → next cycle out_alu = 32'h00008000, overflow = 1, busy never asserted.
- haz1 = 1 following a result of 16'h0005; in_alu.a = 0, b = 3, ADD → out_alu = 32'h00000008.
- MUL 16'h00FF × 16'h0101 → busy high cycles 0–16, bubbles (out_reg_wr = 0) cycles 1–17, out_alu = 32'h0000FFFF in cycle 18. With FAST_MUL_EN: same result in cycle 1.
- DIV 100 / 7 → out_alu = 32'h0002000E in cycle 18, div0 = 0.
- DIV 16'h1234 / 0 → out_alu = 32'h1234FFFF, div0 = 1 in cycle 2.
- rst asserted at cycle 5 of a DIV → next cycle: all outputs 0, busy = 0, FSM IDLE. halt_sys held 3 cycles mid-RUN → completion delayed exactly 3 cycles.
